neos2test_sysid_checker: RTL and testbench
==========================================

# neos2test_sysid_checker

Avalon-MM read master that interrogates the system-ID responder after reset or on request. It reads the ID word and the build-timestamp word, latches both, and flags whether each matches the value baked into the software image's build. It sits beside the boot/reset controller; its `done`/match flags gate CPU release or feed a status LED/CSR.

## Interface

- `BASE_ADDR`, 32'h0000_0000: byte address of the sysid responder; ID at BASE_ADDR, timestamp at BASE_ADDR+4.
- `EXPECTED_ID`, 32'h3939_3939: expected ID word.
- `EXPECTED_TIMESTAMP`, 32'h557D_26D6: expected timestamp word.
- `TIMEOUT_CYCLES`, 256: per-transaction cycle budget, from read assertion to readdatavalid; legal range 2..65535.
- `AUTO_START`, 1: 1 = start one check automatically after reset deassertion.

- `clock` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that requests a check.
- `avm_address` out 32: byte address.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: interconnect stall.
- `avm_readdata` in 32: read data.
- `avm_readdatavalid` in 1: read data qualifier.
- `busy` out 1: check in progress.
- `done` out 1: last check finished (sticky until next start).
- `id_match` out 1: latched ID equals EXPECTED_ID.
- `ts_match` out 1: latched timestamp equals EXPECTED_TIMESTAMP.
- `timeout` out 1: last check aborted on timeout.
- `id_value` out 32: last captured ID word.
- `ts_value` out 32: last captured timestamp word.

## Operation

- States: IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, DONE.
- IDLE→RD_ID on `start`, or on the first cycle after reset if AUTO_START=1. DONE→RD_ID on `start`. `start` is ignored in all other states.
- On entry to RD_ID: clear `done`, `timeout`, `id_match`, `ts_match`. `id_value`/`ts_value` hold their old values until overwritten.
- RD_ID: `avm_read`=1, `avm_address`=BASE_ADDR. Read is accepted when `avm_waitrequest`=0. Address and read stay stable while stalled. On acceptance go to WAIT_ID with `avm_read`=0 the next cycle.
- WAIT_ID: on `avm_readdatavalid`, capture `id_value`, register `id_match`, go to RD_TS.
- RD_TS/WAIT_TS: same pattern at BASE_ADDR+4. Data captures to `ts_value`/`ts_match`, then go to DONE.
- DONE: `done`=1, `busy`=0. Flags hold.
- `avm_readdatavalid` is ignored outside WAIT_ID/WAIT_TS. At most one read is outstanding.
- Timeout: a 16-bit counter clears on entry to RD_ID and RD_TS and increments every cycle in RD_*/WAIT_*. When it reaches TIMEOUT_CYCLES-1 without data, go to DONE with `timeout`=1 and the current match flag left at 0.
- `busy`=1 in RD_*/WAIT_*.
- Compare is a full 32-bit equality with no masking.

## Timing

- Reset values: state IDLE, `avm_read`=0, `avm_address`=BASE_ADDR, `busy`=0, `done`=0, `id_match`=0, `ts_match`=0, `timeout`=0, `id_value`=0, `ts_value`=0, counter 0.
- Reset asserted mid-transaction drops `avm_read` immediately (async). After release, behaviour follows AUTO_START.
- `start` in cycle N puts `avm_read`=1 in cycle N+1.
- The cycle after acceptance has `avm_read`=0. Read data arriving in cycle M gives registered capture/flags visible at M+1. The next read is asserted at M+1.
- With zero waitrequest and latency 1, `start` at cycle 0 gives `done`=1 at cycle 5.
- If data arrives in the same cycle the counter hits its limit, data wins.

## Test plan

- AUTO_START=1, responder returns 0x39393939 and then 0x557D26D6, no stall, latency 1 -> `done`=1 at cycle 5 after reset release; `id_match`=1, `ts_match`=1, `timeout`=0; exactly two reads, at addresses 0x0 and 0x4.
- Timestamp read returns 0x557D26D7 -> `id_match`=1, `ts_match`=0, `ts_value`=0x557D26D7, `done`=1.
- `avm_waitrequest` held high for 10 cycles on the ID read -> `avm_read` and `avm_address` stable for all 11 cycles; exactly one acceptance; correct result.
- TIMEOUT_CYCLES=8, no readdatavalid on the TS read -> `done`=1 and `timeout`=1 eight cycles after the TS read is asserted; `ts_match`=0; a spurious readdatavalid afterwards leaves `ts_value` unchanged.
- `start` pulsed while busy -> ignored, single check completes. `start` pulsed in DONE -> flags clear the next cycle and a fresh check runs.
- `reset_n` asserted during WAIT_TS -> all outputs return to reset values asynchronously; with AUTO_START=1 a new check follows release.

Source files
------------

// File: rtl/neos2test_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and build-timestamp words,
// latches them and reports whether each matches the value expected by this build.
module neos2test_sysid_checker #(
  parameter logic [31:0] BASE_ADDR          = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_ID        = 32'h3939_3939,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h557D_26D6,
  parameter int unsigned TIMEOUT_CYCLES     = 256,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ID   = 3'd1,
    S_WAIT_ID = 3'd2,
    S_RD_TS   = 3'd3,
    S_WAIT_TS = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] TS_ADDR   = BASE_ADDR + 32'd4;

  state_t      state_q, state_d;
  logic        auto_q, auto_d;
  logic [15:0] cnt_q, cnt_d;
  logic        read_q, read_d;
  logic [31:0] addr_q, addr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        id_match_q, id_match_d;
  logic        ts_match_q, ts_match_d;
  logic        timeout_q, timeout_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;
  logic        at_limit_s;
  logic        active_s;
  logic        enter_rd_s;

  // Next-state, data capture and per-transaction timeout logic
  always_comb begin
    state_d    = state_q;
    auto_d     = auto_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    id_match_d = id_match_q;
    ts_match_d = ts_match_q;
    timeout_d  = timeout_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;
    at_limit_s = (cnt_q == CNT_LIMIT);
    active_s   = (state_q == S_RD_ID) || (state_q == S_WAIT_ID) ||
                 (state_q == S_RD_TS) || (state_q == S_WAIT_TS);

    case (state_q)
      S_IDLE: begin
        if (start || auto_q) begin
          state_d = S_RD_ID;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_ID: begin
        if (at_limit_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = S_WAIT_ID;
        end else begin
          state_d = S_RD_ID;
        end
      end
      S_WAIT_ID: begin
        // Data arriving on the limit cycle still counts as a valid response.
        if (avm_readdatavalid) begin
          id_value_d = avm_readdata;
          id_match_d = (avm_readdata == EXPECTED_ID);
          state_d    = S_RD_TS;
        end else if (at_limit_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_WAIT_ID;
        end
      end
      S_RD_TS: begin
        if (at_limit_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else if (!avm_waitrequest) begin
          state_d = S_WAIT_TS;
        end else begin
          state_d = S_RD_TS;
        end
      end
      S_WAIT_TS: begin
        if (avm_readdatavalid) begin
          ts_value_d = avm_readdata;
          ts_match_d = (avm_readdata == EXPECTED_TIMESTAMP);
          state_d    = S_DONE;
        end else if (at_limit_s) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end else begin
          state_d = S_WAIT_TS;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_RD_ID;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    enter_rd_s = ((state_d == S_RD_ID) && (state_q != S_RD_ID)) ||
                 ((state_d == S_RD_TS) && (state_q != S_RD_TS));

    if ((state_d == S_RD_ID) && (state_q != S_RD_ID)) begin
      auto_d     = 1'b0;
      id_match_d = 1'b0;
      ts_match_d = 1'b0;
      timeout_d  = 1'b0;
    end else begin
      auto_d = auto_q;
    end

    if (enter_rd_s) begin
      cnt_d = 16'd0;
    end else if (active_s) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if (state_d == S_RD_TS) begin
      addr_d = TS_ADDR;
    end else if (state_d == S_RD_ID) begin
      addr_d = BASE_ADDR;
    end else begin
      addr_d = addr_q;
    end

    read_d = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    busy_d = read_d || (state_d == S_WAIT_ID) || (state_d == S_WAIT_TS);
    done_d = (state_d == S_DONE);
  end

  // State and output registers; outputs are decoded from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      auto_q     <= AUTO_START;
      cnt_q      <= 16'd0;
      read_q     <= 1'b0;
      addr_q     <= BASE_ADDR;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      id_match_q <= 1'b0;
      ts_match_q <= 1'b0;
      timeout_q  <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      auto_q     <= auto_d;
      cnt_q      <= cnt_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      id_match_q <= id_match_d;
      ts_match_q <= ts_match_d;
      timeout_q  <= timeout_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_match    = id_match_q;
  assign ts_match    = ts_match_q;
  assign timeout     = timeout_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_neos2test_sysid_checker.sv
// Bench for neos2test_sysid_checker: a configurable Avalon responder plus a
// transaction-level timing/result model of each check.
module tb_neos2test_sysid_checker;

  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] EXP_ID = 32'h3939_3939;
  localparam logic [31:0] EXP_TS = 32'h557D_26D6;
  localparam int          TO     = 16;
  localparam int          LIMIT  = TO - 1;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy, done, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  always #5 clock = ~clock;

  neos2test_sysid_checker #(
    .BASE_ADDR(BASE), .EXPECTED_ID(EXP_ID), .EXPECTED_TIMESTAMP(EXP_TS),
    .TIMEOUT_CYCLES(TO), .AUTO_START(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_match(id_match), .ts_match(ts_match),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  // Responder configuration (written by the stimulus, read by the responder)
  int          rsp_stall [2];
  int          rsp_lat   [2];
  logic [31:0] rsp_data  [2];
  int          check_id = 0;

  // Responder-owned bookkeeping
  int          seen_id = 0;
  bit          in_req = 1'b0;
  bit          pend = 1'b0;
  int          stall_cnt = 0;
  int          lat_cnt = 0;
  int          sel = 0;
  logic [31:0] pend_data = 32'd0;
  logic [31:0] req_addr = 32'd0;
  int          accepts = 0;
  int          read_cycles = 0;
  int          stab_err = 0;
  logic [31:0] addr_log [$];

  logic [31:0] model_id = 32'd0;
  logic [31:0] model_ts = 32'd0;

  // Avalon responder: drives inputs on the falling edge from the configured stall/latency
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = 32'd0;
    forever begin
      @(negedge clock);
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (seen_id != check_id) begin
        seen_id = check_id;
        pend    = 1'b0;
      end
      if (!reset_n) begin
        in_req = 1'b0;
        pend   = 1'b0;
      end else begin
        if (pend) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
            pend              = 1'b0;
          end
        end
        if (avm_read) begin
          sel = (avm_address == BASE + 32'd4) ? 1 : 0;
          if (!in_req) begin
            in_req    = 1'b1;
            stall_cnt = rsp_stall[sel];
            req_addr  = avm_address;
          end else if (avm_address !== req_addr) begin
            stab_err++;
          end
          read_cycles++;
          if (stall_cnt > 0) begin
            avm_waitrequest = 1'b1;
            stall_cnt--;
          end else begin
            in_req = 1'b0;
            accepts++;
            addr_log.push_back(avm_address);
            pend      = 1'b1;
            lat_cnt   = rsp_lat[sel];
            pend_data = rsp_data[sel];
          end
        end else begin
          in_req = 1'b0;
        end
      end
    end
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk32({tag, "_read"},    32'(avm_read),  32'd0);
    chk32({tag, "_addr"},    avm_address,    BASE);
    chk32({tag, "_busy"},    32'(busy),      32'd0);
    chk32({tag, "_done"},    32'(done),      32'd0);
    chk32({tag, "_idm"},     32'(id_match),  32'd0);
    chk32({tag, "_tsm"},     32'(ts_match),  32'd0);
    chk32({tag, "_timeout"}, 32'(timeout),   32'd0);
    chk32({tag, "_idv"},     id_value,       32'd0);
    chk32({tag, "_tsv"},     ts_value,       32'd0);
  endtask

  // One full check: model predicts completion cycle and results from stall/latency/data
  task automatic run_check(input string tag, input bit via_reset,
                           input int w0, input int l0, input logic [31:0] d0,
                           input int w1, input int l1, input logic [31:0] d1,
                           input int poke_at);
    int          done_at, s1, exp_reads, seen_done, acc0, rc0, log0;
    bit          got0, got1;
    logic [31:0] exp_addr [$];

    got0 = (w0 < LIMIT) && (w0 + l0 <= LIMIT);
    got1 = 1'b0;
    exp_reads = (w0 < LIMIT) ? w0 + 1 : LIMIT + 1;
    if (w0 < LIMIT) exp_addr.push_back(BASE);
    if (!got0) begin
      done_at = 1 + LIMIT + 1;
    end else begin
      s1   = 1 + w0 + l0 + 1;
      got1 = (w1 < LIMIT) && (w1 + l1 <= LIMIT);
      exp_reads += (w1 < LIMIT) ? w1 + 1 : LIMIT + 1;
      if (w1 < LIMIT) exp_addr.push_back(BASE + 32'd4);
      done_at = got1 ? s1 + w1 + l1 + 1 : s1 + LIMIT + 1;
    end
    if (got0) model_id = d0;
    if (got1) model_ts = d1;

    rsp_stall[0] = w0; rsp_lat[0] = l0; rsp_data[0] = d0;
    rsp_stall[1] = w1; rsp_lat[1] = l1; rsp_data[1] = d1;
    check_id++;
    acc0 = accepts; rc0 = read_cycles; log0 = addr_log.size();

    if (via_reset) reset_n = 1'b1;
    else start = 1'b1;
    seen_done = -1;
    for (int c = 1; c <= 200 && seen_done < 0; c++) begin
      @(posedge clock); #1;
      start = (c == poke_at) ? 1'b1 : 1'b0;
      if (c == 1) begin
        chk32({tag, "_c1_busy"}, 32'(busy), 32'd1);
        chk32({tag, "_c1_read"}, 32'(avm_read), 32'd1);
        chk32({tag, "_c1_flags"}, {28'd0, done, timeout, id_match, ts_match}, 32'd0);
      end
      if (done) seen_done = c;
    end
    start = 1'b0;
    chk32({tag, "_done_cycle"}, 32'(seen_done), 32'(done_at));

    repeat (40) begin @(posedge clock); #1; end
    chk32({tag, "_done"},    32'(done),     32'd1);
    chk32({tag, "_busy"},    32'(busy),     32'd0);
    chk32({tag, "_timeout"}, 32'(timeout),  32'(!(got0 && got1)));
    chk32({tag, "_idm"},     32'(id_match), 32'(got0 && (d0 == EXP_ID)));
    chk32({tag, "_tsm"},     32'(ts_match), 32'(got1 && (d1 == EXP_TS)));
    chk32({tag, "_idv"},     id_value,      model_id);
    chk32({tag, "_tsv"},     ts_value,      model_ts);
    chk32({tag, "_accepts"}, 32'(accepts - acc0), 32'(exp_addr.size()));
    chk32({tag, "_rdcyc"},   32'(read_cycles - rc0), 32'(exp_reads));
    for (int i = 0; i < exp_addr.size() && (log0 + i) < addr_log.size(); i++)
      chk32({tag, "_addr"}, addr_log[log0 + i], exp_addr[i]);
    chk32({tag, "_stable"},  32'(stab_err), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    rsp_stall[0] = 0; rsp_stall[1] = 0; rsp_lat[0] = 1; rsp_lat[1] = 1;
    rsp_data[0] = EXP_ID; rsp_data[1] = EXP_TS;
    repeat (3) @(posedge clock);
    #1;
    check_reset("rst");

    run_check("auto",    1'b1, 0, 1, EXP_ID, 0, 1, EXP_TS, 0);
    run_check("ts_bad",  1'b0, 0, 1, EXP_ID, 0, 1, 32'h557D_26D7, 0);
    run_check("id_bad",  1'b0, 1, 2, 32'h3939_3938, 2, 1, EXP_TS, 0);
    run_check("stall10", 1'b0, 10, 1, EXP_ID, 0, 1, EXP_TS, 0);
    run_check("to_wait", 1'b0, 0, 1, EXP_ID, 0, LIMIT + 5, EXP_TS, 0);
    run_check("to_rd",   1'b0, 0, 1, EXP_ID, LIMIT + 3, 1, EXP_TS, 0);
    run_check("at_lim",  1'b0, 4, LIMIT - 4, EXP_ID, 0, 1, EXP_TS, 0);
    run_check("past_lim",1'b0, 4, LIMIT - 3, 32'h1234_5678, 0, 1, EXP_TS, 0);
    run_check("poke",    1'b0, 0, 2, EXP_ID, 1, 1, EXP_TS, 2);

    // Reset asserted while the timestamp read is outstanding
    rsp_stall[0] = 0; rsp_lat[0] = 1; rsp_data[0] = EXP_ID;
    rsp_stall[1] = 0; rsp_lat[1] = 30; rsp_data[1] = EXP_TS;
    check_id++;
    start = 1'b1;
    repeat (4) begin @(posedge clock); #1; start = 1'b0; end
    chk32("mid_idv", id_value, EXP_ID);
    chk32("mid_read", 32'(avm_read), 32'd0);
    reset_n = 1'b0;
    #1;
    check_reset("mid_rst");
    model_id = 32'd0;
    model_ts = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    run_check("post_rst", 1'b1, 0, 3, EXP_ID, 2, 2, EXP_TS, 0);

    for (int r = 0; r < 12; r++) begin
      int          w0, l0, w1, l1;
      logic [31:0] d0, d1;
      w0 = ($urandom_range(0, 7) == 0) ? LIMIT + 3 : int'($urandom_range(0, 6));
      w1 = ($urandom_range(0, 7) == 0) ? LIMIT + 3 : int'($urandom_range(0, 6));
      l0 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 24)) : int'($urandom_range(1, 4));
      l1 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(6, 24)) : int'($urandom_range(1, 4));
      d0 = ($urandom_range(0, 1) == 0) ? EXP_ID : EXP_ID ^ (32'd1 << $urandom_range(0, 31));
      d1 = ($urandom_range(0, 1) == 0) ? EXP_TS : EXP_TS ^ (32'd1 << $urandom_range(0, 31));
      run_check("rand", 1'b0, w0, l0, d0, w1, l1, d1, int'($urandom_range(0, 4)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
